// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the hardwired control sequencer: state codes, opcodes, ALU op codes
// and the per-opcode final T-step.
package control_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_RESET  = 4'd0,
      ST_T0     = 4'd1,
      ST_T1     = 4'd2,
      ST_T2     = 4'd3,
      ST_T3     = 4'd4,
      ST_T4     = 4'd5,
      ST_T5     = 4'd6,
      ST_T6     = 4'd7,
      ST_T7     = 4'd8,
      ST_HALTED = 4'd9
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = 5'b00011;

   // Index of the last T-step of an instruction; unknown opcodes end after fetch like nop.
   function automatic logic [2:0] last_step(input logic [4:0] op);
      logic [2:0] step;
      case (op)
         OP_LD, OP_ST:                                     step = 3'd7;
         OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:   step = 3'd5;
         OP_BR:                                            step = 3'd6;
         OP_JR:                                            step = 3'd3;
         default:                                          step = 3'd2;
      endcase
      return step;
   endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch T0-T2 then an opcode-specific execute sequence,
// decoding every DataPath strobe and the ALU op from the current state.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int OPW = 5,
   parameter int IRW = 32
) (
   input  logic           clock,
   input  logic           clear,
   input  logic [IRW-1:0] ir,
   input  logic           con_ff,
   input  logic           stop,
   output logic           run,
   output logic           gra,
   output logic           grb,
   output logic           grc,
   output logic           rin,
   output logic           rout,
   output logic           BAout,
   output logic           PCout,
   output logic           PCin,
   output logic           IncPC,
   output logic           MARin,
   output logic           MDRin,
   output logic           MDRout,
   output logic           Read,
   output logic           Write,
   output logic           IRin,
   output logic           RYin,
   output logic           RZin,
   output logic           RZLOout,
   output logic           Cout,
   output logic           CONin,
   output logic [OPW-1:0] ops
);

   state_t         state;
   state_t         next_state;
   logic [OPW-1:0] ir_op;
   logic [OPW-1:0] opcode_q;
   logic [OPW-1:0] cur_op;
   logic [3:0]     step_full;
   logic [2:0]     step;
   logic           unused_ir_bits;

   assign ir_op          = ir[IRW-1 -: OPW];
   assign unused_ir_bits = ^ir[IRW-OPW-1:0];
   assign step_full      = state - ST_T0;
   assign step           = step_full[2:0];

   // IR is loaded at the end of T2, so the T2 exit decision looks at ir directly and
   // the opcode is captured on that same edge for the execute steps.
   always_comb begin
      cur_op     = (state == ST_T2) ? ir_op : opcode_q;
      next_state = ST_RESET;
      case (state)
         ST_RESET:  next_state = ST_T0;
         ST_HALTED: next_state = ST_HALTED;
         ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
            if (state == ST_T2 && ir_op == OP_HALT)
               next_state = ST_HALTED;
            else if (step == last_step(cur_op))
               next_state = stop ? ST_HALTED : ST_T0;
            else
               next_state = state_t'(state + 4'd1);
         end
         default:   next_state = ST_RESET;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state    <= ST_RESET;
         opcode_q <= '0;
      end else begin
         state <= next_state;
         if (state == ST_T2)
            opcode_q <= ir_op;
      end
   end

   // Moore decode: one case over the state, execute steps further split by opcode.
   always_comb begin
      run     = 1'b0;
      gra     = 1'b0;
      grb     = 1'b0;
      grc     = 1'b0;
      rin     = 1'b0;
      rout    = 1'b0;
      BAout   = 1'b0;
      PCout   = 1'b0;
      PCin    = 1'b0;
      IncPC   = 1'b0;
      MARin   = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      Read    = 1'b0;
      Write   = 1'b0;
      IRin    = 1'b0;
      RYin    = 1'b0;
      RZin    = 1'b0;
      RZLOout = 1'b0;
      Cout    = 1'b0;
      CONin   = 1'b0;
      ops     = ALU_NONE;
      case (state)
         ST_T0: begin
            run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
         end
         ST_T1: begin
            run = 1'b1; RZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         ST_T2: begin
            run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
         end
         ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
            run = 1'b1;
            case (opcode_q)
               OP_LD, OP_LDI, OP_ST: begin
                  case (state)
                     ST_T3: begin grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
                     ST_T4: begin Cout = 1'b1; RZin = 1'b1; ops = ALU_ADD; end
                     ST_T5: begin
                        RZLOout = 1'b1;
                        if (opcode_q == OP_LDI) begin
                           gra = 1'b1; rin = 1'b1;
                        end else begin
                           MARin = 1'b1;
                        end
                     end
                     ST_T6: begin
                        MDRin = 1'b1;
                        if (opcode_q == OP_ST) begin
                           gra = 1'b1; rout = 1'b1;
                        end else begin
                           Read = 1'b1;
                        end
                     end
                     ST_T7: begin
                        if (opcode_q == OP_ST) begin
                           Write = 1'b1;
                        end else begin
                           MDRout = 1'b1; gra = 1'b1; rin = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                  case (state)
                     ST_T3: begin grb = 1'b1; rout = 1'b1; RYin = 1'b1; end
                     ST_T4: begin
                        RZin = 1'b1;
                        if (opcode_q == OP_ADDI) begin
                           Cout = 1'b1; ops = ALU_ADD;
                        end else begin
                           grc = 1'b1; rout = 1'b1; ops = opcode_q;
                        end
                     end
                     ST_T5: begin RZLOout = 1'b1; gra = 1'b1; rin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_BR: begin
                  case (state)
                     ST_T3: begin gra = 1'b1; rout = 1'b1; CONin = 1'b1; end
                     ST_T4: begin PCout = 1'b1; RYin = 1'b1; end
                     ST_T5: begin Cout = 1'b1; RZin = 1'b1; ops = ALU_ADD; end
                     ST_T6: begin RZLOout = con_ff; PCin = con_ff; end
                     default: ;
                  endcase
               end
               OP_JR: begin
                  if (state == ST_T3) begin
                     gra = 1'b1; rout = 1'b1; PCin = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a reference model pushes the expected strobe
// vector for every cycle into a queue, and a negedge monitor pops and compares it.
module tb_control_sequencer;

   localparam logic [25:0] M_RUN    = 26'h1 << 25;
   localparam logic [25:0] M_GRA    = 26'h1 << 24;
   localparam logic [25:0] M_GRB    = 26'h1 << 23;
   localparam logic [25:0] M_GRC    = 26'h1 << 22;
   localparam logic [25:0] M_RIN    = 26'h1 << 21;
   localparam logic [25:0] M_ROUT   = 26'h1 << 20;
   localparam logic [25:0] M_BAOUT  = 26'h1 << 19;
   localparam logic [25:0] M_PCOUT  = 26'h1 << 18;
   localparam logic [25:0] M_PCIN   = 26'h1 << 17;
   localparam logic [25:0] M_INCPC  = 26'h1 << 16;
   localparam logic [25:0] M_MARIN  = 26'h1 << 15;
   localparam logic [25:0] M_MDRIN  = 26'h1 << 14;
   localparam logic [25:0] M_MDROUT = 26'h1 << 13;
   localparam logic [25:0] M_READ   = 26'h1 << 12;
   localparam logic [25:0] M_WRITE  = 26'h1 << 11;
   localparam logic [25:0] M_IRIN   = 26'h1 << 10;
   localparam logic [25:0] M_RYIN   = 26'h1 << 9;
   localparam logic [25:0] M_RZIN   = 26'h1 << 8;
   localparam logic [25:0] M_RZLO   = 26'h1 << 7;
   localparam logic [25:0] M_COUT   = 26'h1 << 6;
   localparam logic [25:0] M_CONIN  = 26'h1 << 5;

   typedef struct {
      string       tag;
      logic [25:0] vec;
   } exp_t;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] ir;
   logic        con_ff;
   logic        stop;
   logic        run, gra, grb, grc, rin, rout, BAout, PCout, PCin, IncPC;
   logic        MARin, MDRin, MDRout, Read, Write, IRin, RYin, RZin, RZLOout, Cout, CONin;
   logic [4:0]  ops;
   logic [25:0] obs;
   logic [5:0]  bus;
   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;

   control_sequencer dut (
      .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
      .run(run), .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
      .BAout(BAout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
      .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
      .IRin(IRin), .RYin(RYin), .RZin(RZin), .RZLOout(RZLOout), .Cout(Cout),
      .CONin(CONin), .ops(ops)
   );

   always #5 clock = ~clock;

   assign obs = {run, gra, grb, grc, rin, rout, BAout, PCout, PCin, IncPC, MARin, MDRin,
                 MDRout, Read, Write, IRin, RYin, RZin, RZLOout, Cout, CONin, ops};
   assign bus = {rout, BAout, PCout, MDRout, RZLOout, Cout};

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Expected strobes for T-step s of an instruction with opcode op.
   function automatic logic [25:0] model(input int s, input logic [4:0] op, input logic con);
      logic [25:0] v;
      v = M_RUN;
      case (s)
         0: v |= M_PCOUT | M_MARIN | M_INCPC | M_RZIN;
         1: v |= M_RZLO | M_PCIN | M_READ | M_MDRIN;
         2: v |= M_MDROUT | M_IRIN;
         default: begin
            case (op)
               5'b00000: case (s)
                  3: v |= M_GRB | M_BAOUT | M_RYIN;
                  4: v |= M_COUT | M_RZIN | 26'd3;
                  5: v |= M_RZLO | M_MARIN;
                  6: v |= M_READ | M_MDRIN;
                  7: v |= M_MDROUT | M_GRA | M_RIN;
                  default: ;
               endcase
               5'b00001: case (s)
                  3: v |= M_GRB | M_BAOUT | M_RYIN;
                  4: v |= M_COUT | M_RZIN | 26'd3;
                  5: v |= M_RZLO | M_GRA | M_RIN;
                  default: ;
               endcase
               5'b00010: case (s)
                  3: v |= M_GRB | M_BAOUT | M_RYIN;
                  4: v |= M_COUT | M_RZIN | 26'd3;
                  5: v |= M_RZLO | M_MARIN;
                  6: v |= M_GRA | M_ROUT | M_MDRIN;
                  7: v |= M_WRITE;
                  default: ;
               endcase
               5'b00011, 5'b00100, 5'b00101, 5'b00110: case (s)
                  3: v |= M_GRB | M_ROUT | M_RYIN;
                  4: v |= M_GRC | M_ROUT | M_RZIN | 26'(op);
                  5: v |= M_RZLO | M_GRA | M_RIN;
                  default: ;
               endcase
               5'b01100: case (s)
                  3: v |= M_GRB | M_ROUT | M_RYIN;
                  4: v |= M_COUT | M_RZIN | 26'd3;
                  5: v |= M_RZLO | M_GRA | M_RIN;
                  default: ;
               endcase
               5'b10010: case (s)
                  3: v |= M_GRA | M_ROUT | M_CONIN;
                  4: v |= M_PCOUT | M_RYIN;
                  5: v |= M_COUT | M_RZIN | 26'd3;
                  6: if (con) v |= M_RZLO | M_PCIN;
                  default: ;
               endcase
               5'b10100: if (s == 3) v |= M_GRA | M_ROUT | M_PCIN;
               default: ;
            endcase
         end
      endcase
      return v;
   endfunction

   function automatic int cpi(input logic [4:0] op);
      case (op)
         5'b00000, 5'b00010:                               return 8;
         5'b00001, 5'b00011, 5'b00100, 5'b00101,
         5'b00110, 5'b01100:                               return 6;
         5'b10010:                                         return 7;
         5'b10100:                                         return 4;
         default:                                          return 3;
      endcase
   endfunction

   // Monitor: pop one expectation per cycle and check the bus-driver invariant.
   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checkOutput(mon_e.tag, 32'(obs), 32'(mon_e.vec));
      end
      checkOutput("bus_onehot", 32'($countones(bus) <= 1), 32'd1);
   end

   task automatic doClear();
      clear = 1'b1;
      exp_q.push_back('{tag: "clear_asserted", vec: 26'd0});
      @(posedge clock); #1;
      clear = 1'b0;
      exp_q.push_back('{tag: "clear_released", vec: 26'd0});
      @(posedge clock); #1;
   endtask

   // Entered one time unit after the edge that starts T0; leaves at the next T0 (or after recovery).
   task automatic applyStimulus(input string tag, input logic [31:0] ir_val,
                                input logic con, input logic stop_val);
      logic [4:0] op;
      int         n;
      op     = ir_val[31:27];
      n      = cpi(op);
      con_ff = con;
      stop   = stop_val;
      for (int s = 0; s < n; s++) begin
         if (s == 2) ir = ir_val;
         exp_q.push_back('{tag: $sformatf("%s T%0d", tag, s), vec: model(s, op, con)});
         @(posedge clock); #1;
      end
      if (op == 5'b11011 || stop_val) begin
         for (int h = 0; h < 3; h++) begin
            exp_q.push_back('{tag: $sformatf("%s halted%0d", tag, h), vec: 26'd0});
            @(posedge clock); #1;
         end
         stop = 1'b0;
         doClear();
      end
   endtask

   initial begin
      clear  = 1'b1;
      ir     = 32'h0;
      con_ff = 1'b0;
      stop   = 1'b0;
      @(posedge clock); #1;
      doClear();

      // ld interrupted by clear in the middle of T4
      con_ff = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if (s == 2) ir = 32'h00800075;
         exp_q.push_back('{tag: $sformatf("ld_abort T%0d", s), vec: model(s, 5'b00000, 1'b0)});
         @(posedge clock); #1;
      end
      exp_q.push_back('{tag: "ld_abort midT4", vec: 26'd0});
      #2 clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      exp_q.push_back('{tag: "ld_abort released", vec: 26'd0});
      @(posedge clock); #1;

      applyStimulus("ld",     32'h00800075, 1'b0, 1'b0);
      applyStimulus("add",    32'h1A118000, 1'b0, 1'b0);
      applyStimulus("br_nt",  32'h90800010, 1'b0, 1'b0);
      applyStimulus("br_tk",  32'h90800010, 1'b1, 1'b0);
      applyStimulus("st",     32'h10800020, 1'b0, 1'b0);
      applyStimulus("ldi",    32'h08800005, 1'b0, 1'b0);
      applyStimulus("sub",    32'h22118000, 1'b0, 1'b0);
      applyStimulus("and",    32'h2A118000, 1'b0, 1'b0);
      applyStimulus("or",     32'h32118000, 1'b0, 1'b0);
      applyStimulus("addi",   32'h60880004, 1'b0, 1'b0);
      applyStimulus("jr",     32'hA0800000, 1'b0, 1'b0);
      applyStimulus("nop",    32'hD0000000, 1'b0, 1'b0);
      applyStimulus("unk",    32'h78000000, 1'b0, 1'b0);
      applyStimulus("halt",   32'hD8000000, 1'b0, 1'b0);
      applyStimulus("add_st", 32'h1A118000, 1'b0, 1'b1);
      applyStimulus("ld_end", 32'h00800075, 1'b0, 1'b0);

      @(negedge clock); #1;
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
